// File: rtl/warp_bank_reg_file_pkg.sv
// Shared types for the multi-warp banked register file: lane data word, write-back
// source select and the warp-init sequencer states.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package warp_bank_reg_file_pkg;

    localparam int unsigned DATA_WIDTH = `DATA_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        ALU_OUT,
        LSU_OUT,
        IMMEDIATE,
        VECTOR_TO_SCALAR
    } reg_input_mux_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LOAD
    } init_state_t;

endpackage

// File: rtl/warp_bank_reg_file_scoreboard.sv
// Per-warp busy bits for registers with an outstanding write-back, plus a two-source
// hazard query used to stall operand reads.
module warp_bank_reg_file_scoreboard #(
    parameter int unsigned NUM_WARPS = 4,
    parameter int unsigned NUM_REGS  = 32,
    localparam int unsigned WW = $clog2(NUM_WARPS),
    localparam int unsigned RW = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr_warp_en,
    input  logic [WW-1:0] clr_warp_idx,
    input  logic          clr_en,
    input  logic [WW-1:0] clr_warp,
    input  logic [RW-1:0] clr_reg,
    input  logic          set_en,
    input  logic [WW-1:0] set_warp,
    input  logic [RW-1:0] set_reg,
    input  logic [WW-1:0] q_warp,
    input  logic [RW-1:0] q_rs1,
    input  logic [RW-1:0] q_rs2,
    output logic          hazard
);

    logic [NUM_REGS-1:0] busy_q [NUM_WARPS];

    // Later assignments take priority: a reservation beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                busy_q[w] <= '0;
            end
        end else begin
            if (clr_warp_en) begin
                busy_q[clr_warp_idx] <= '0;
            end
            if (clr_en) begin
                busy_q[clr_warp][clr_reg] <= 1'b0;
            end
            if (set_en) begin
                busy_q[set_warp][set_reg] <= 1'b1;
            end
        end
    end

    assign hazard = busy_q[q_warp][q_rs1] | busy_q[q_warp][q_rs2];

endmodule

// File: rtl/warp_bank_reg_file.sv
// Banked per-thread register file for NUM_WARPS warps: registered operand reads with
// scoreboard stalls, masked write-back and a warp-init clear/load sequencer.
module warp_bank_reg_file
    import warp_bank_reg_file_pkg::*;
#(
    parameter int unsigned NUM_WARPS        = 4,
    parameter int unsigned THREADS_PER_WARP = 16,
    parameter int unsigned NUM_REGS         = 32,
    localparam int unsigned WW = $clog2(NUM_WARPS),
    localparam int unsigned RW = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        init_valid,
    output logic                        init_ready,
    input  logic [WW-1:0]               init_warp,
    input  data_t                       init_block_id,
    input  data_t                       init_block_size,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    input  logic [WW-1:0]               rd_warp,
    input  logic [RW-1:0]               rd_rs1,
    input  logic [RW-1:0]               rd_rs2,
    input  logic [THREADS_PER_WARP-1:0] rd_mask,
    input  logic                        rd_reserve,
    input  logic [RW-1:0]               rd_dst,
    output logic                        resp_valid,
    output data_t                       rs1_data [THREADS_PER_WARP],
    output data_t                       rs2_data [THREADS_PER_WARP],
    input  logic                        wb_valid,
    input  logic [WW-1:0]               wb_warp,
    input  logic [RW-1:0]               wb_rd,
    input  logic [THREADS_PER_WARP-1:0] wb_mask,
    input  reg_input_mux_t              wb_src,
    input  data_t                       alu_out [THREADS_PER_WARP],
    input  data_t                       lsu_out [THREADS_PER_WARP],
    input  data_t                       wb_imm,
    output logic                        err_sticky
);

    localparam logic [RW-1:0] TID      = RW'(NUM_REGS - 3);
    localparam logic [RW-1:0] BID      = RW'(NUM_REGS - 2);
    localparam logic [RW-1:0] BSZ      = RW'(NUM_REGS - 1);
    localparam logic [RW-1:0] LAST_GPR = RW'(NUM_REGS - 4);

    init_state_t   state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] init_warp_q;
    data_t         block_id_q, block_size_q;
    logic          init_start;

    data_t gpr_q [NUM_WARPS][THREADS_PER_WARP][NUM_REGS];
    data_t bid_q [NUM_WARPS];
    data_t bsz_q [NUM_WARPS];

    logic          idle, hazard, rd_accept, rd_set;
    logic          wb_rd_ok, wb_conflict, wb_we, wb_illegal;
    logic [RW-1:0] rd_src [2];
    data_t         wb_data [THREADS_PER_WARP];
    data_t         rd_val [2][THREADS_PER_WARP];
    logic          resp_valid_q, err_q;
    data_t         rs1_q [THREADS_PER_WARP];
    data_t         rs2_q [THREADS_PER_WARP];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        init_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (init_valid) begin
                    init_start = 1'b1;
                    state_d    = CLEAR;
                    cnt_d      = RW'(1);
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_GPR) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            init_warp_q  <= '0;
            block_id_q   <= '0;
            block_size_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (init_start) begin
                init_warp_q  <= init_warp;
                block_id_q   <= init_block_id;
                block_size_q <= init_block_size;
            end
        end
    end

    assign idle       = (state_q == IDLE);
    assign init_ready = idle;

    assign wb_rd_ok    = (wb_rd != '0) && (wb_rd < TID);
    assign wb_conflict = !idle && (wb_warp == init_warp_q);
    assign wb_illegal  = wb_valid && (!wb_rd_ok || wb_conflict);
    assign wb_we       = wb_valid && wb_rd_ok && !wb_conflict && (wb_src != VECTOR_TO_SCALAR);

    always_comb begin
        for (int l = 0; l < THREADS_PER_WARP; l++) begin
            wb_data[l] = '0;
            unique case (wb_src)
                ALU_OUT:          wb_data[l] = alu_out[l];
                LSU_OUT:          wb_data[l] = lsu_out[l];
                IMMEDIATE:        wb_data[l] = wb_imm;
                VECTOR_TO_SCALAR: wb_data[l] = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                bid_q[w] <= '0;
                bsz_q[w] <= '0;
                for (int l = 0; l < THREADS_PER_WARP; l++) begin
                    for (int r = 0; r < NUM_REGS; r++) begin
                        gpr_q[w][l][r] <= '0;
                    end
                end
            end
        end else begin
            // The init warp never takes write-backs, so clear and wb cannot collide.
            if (state_q == CLEAR) begin
                for (int l = 0; l < THREADS_PER_WARP; l++) begin
                    gpr_q[init_warp_q][l][cnt_q] <= '0;
                end
            end
            if (state_q == LOAD) begin
                bid_q[init_warp_q] <= block_id_q;
                bsz_q[init_warp_q] <= block_size_q;
            end
            if (wb_we) begin
                for (int l = 0; l < THREADS_PER_WARP; l++) begin
                    if (wb_mask[l]) begin
                        gpr_q[wb_warp][l][wb_rd] <= wb_data[l];
                    end
                end
            end
        end
    end

    assign rd_src[0] = rd_rs1;
    assign rd_src[1] = rd_rs2;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            for (int l = 0; l < THREADS_PER_WARP; l++) begin
                rd_val[s][l] = '0;
                if (rd_mask[l]) begin
                    if (rd_src[s] == TID) begin
                        rd_val[s][l] = data_t'(int'(rd_warp) * int'(THREADS_PER_WARP) + l);
                    end else if (rd_src[s] == BID) begin
                        rd_val[s][l] = bid_q[rd_warp];
                    end else if (rd_src[s] == BSZ) begin
                        rd_val[s][l] = bsz_q[rd_warp];
                    end else if (rd_src[s] != '0) begin
                        if (wb_we && wb_mask[l] && (wb_warp == rd_warp) && (wb_rd == rd_src[s])) begin
                            rd_val[s][l] = wb_data[l];
                        end else begin
                            rd_val[s][l] = gpr_q[rd_warp][l][rd_src[s]];
                        end
                    end
                end
            end
        end
    end

    assign rd_ready  = reset_n && idle && !hazard;
    assign rd_accept = rd_valid && rd_ready;
    assign rd_set    = rd_accept && rd_reserve && (rd_dst != '0) && (rd_dst < TID);

    warp_bank_reg_file_scoreboard #(
        .NUM_WARPS (NUM_WARPS),
        .NUM_REGS  (NUM_REGS)
    ) u_scoreboard (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr_warp_en  (init_start),
        .clr_warp_idx (init_warp),
        .clr_en       (wb_valid),
        .clr_warp     (wb_warp),
        .clr_reg      (wb_rd),
        .set_en       (rd_set),
        .set_warp     (rd_warp),
        .set_reg      (rd_dst),
        .q_warp       (rd_warp),
        .q_rs1        (rd_rs1),
        .q_rs2        (rd_rs2),
        .hazard       (hazard)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            for (int l = 0; l < THREADS_PER_WARP; l++) begin
                rs1_q[l] <= '0;
                rs2_q[l] <= '0;
            end
        end else begin
            resp_valid_q <= rd_accept;
            err_q        <= err_q | wb_illegal;
            if (rd_accept) begin
                for (int l = 0; l < THREADS_PER_WARP; l++) begin
                    rs1_q[l] <= rd_val[0][l];
                    rs2_q[l] <= rd_val[1][l];
                end
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign err_sticky = err_q;
    assign rs1_data   = rs1_q;
    assign rs2_data   = rs2_q;

endmodule

// File: tb/tb_warp_bank_reg_file.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural model of the register file.
module tb_warp_bank_reg_file;
    import warp_bank_reg_file_pkg::*;

    localparam int NW  = 4;
    localparam int TPW = 16;
    localparam int NR  = 32;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           init_valid = 1'b0, init_ready;
    logic [1:0]     init_warp = '0;
    data_t          init_block_id = '0, init_block_size = '0;
    logic           rd_valid = 1'b0, rd_ready;
    logic [1:0]     rd_warp = '0;
    logic [4:0]     rd_rs1 = '0, rd_rs2 = '0, rd_dst = '0;
    logic [TPW-1:0] rd_mask = '0;
    logic           rd_reserve = 1'b0;
    logic           resp_valid;
    data_t          rs1_data [TPW];
    data_t          rs2_data [TPW];
    logic           wb_valid = 1'b0;
    logic [1:0]     wb_warp = '0;
    logic [4:0]     wb_rd = '0;
    logic [TPW-1:0] wb_mask = '0;
    reg_input_mux_t wb_src = ALU_OUT;
    data_t          alu_out [TPW];
    data_t          lsu_out [TPW];
    data_t          wb_imm = '0;
    logic           err_sticky;

    int checks = 0;
    int failures = 0;

    warp_bank_reg_file dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .init_valid      (init_valid),
        .init_ready      (init_ready),
        .init_warp       (init_warp),
        .init_block_id   (init_block_id),
        .init_block_size (init_block_size),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .rd_warp         (rd_warp),
        .rd_rs1          (rd_rs1),
        .rd_rs2          (rd_rs2),
        .rd_mask         (rd_mask),
        .rd_reserve      (rd_reserve),
        .rd_dst          (rd_dst),
        .resp_valid      (resp_valid),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .wb_valid        (wb_valid),
        .wb_warp         (wb_warp),
        .wb_rd           (wb_rd),
        .wb_mask         (wb_mask),
        .wb_src          (wb_src),
        .alu_out         (alu_out),
        .lsu_out         (lsu_out),
        .wb_imm          (wb_imm),
        .err_sticky      (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    data_t m_gpr [NW][TPW][NR];
    data_t m_bid [NW];
    data_t m_bsz [NW];
    bit    m_busy [NW][NR];
    int    m_init_age;      // 0 = idle, 1..NR-4 = clearing register age, NR-3 = loading
    int    m_init_w;
    data_t m_init_bid, m_init_bsz;
    bit    m_resp_valid, m_err;
    data_t m_rs1 [TPW];
    data_t m_rs2 [TPW];

    function automatic data_t m_read(input int w, input int r, input int l);
        if (r == 0) return '0;
        if (r == NR - 3) return data_t'(w * TPW + l);
        if (r == NR - 2) return m_bid[w];
        if (r == NR - 1) return m_bsz[w];
        return m_gpr[w][l][r];
    endfunction

    function automatic data_t m_src(input int l);
        case (wb_src)
            ALU_OUT:   return alu_out[l];
            LSU_OUT:   return lsu_out[l];
            IMMEDIATE: return wb_imm;
            default:   return '0;
        endcase
    endfunction

    bit m_idle, m_acc_rd, m_acc_init, m_rd_legal, m_conflict;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NW; w++) begin
                m_bid[w] = '0;
                m_bsz[w] = '0;
                for (int r = 0; r < NR; r++) m_busy[w][r] = 1'b0;
                for (int l = 0; l < TPW; l++)
                    for (int r = 0; r < NR; r++) m_gpr[w][l][r] = '0;
            end
            for (int l = 0; l < TPW; l++) begin
                m_rs1[l] = '0;
                m_rs2[l] = '0;
            end
            m_init_age = 0;
            m_init_w = 0;
            m_resp_valid = 1'b0;
            m_err = 1'b0;
        end else begin
            m_idle     = (m_init_age == 0);
            m_acc_rd   = rd_valid && m_idle && !m_busy[rd_warp][rd_rs1] && !m_busy[rd_warp][rd_rs2];
            m_acc_init = init_valid && m_idle;
            m_rd_legal = (wb_rd >= 1) && (wb_rd <= NR - 4);
            m_conflict = !m_idle && (int'(wb_warp) == m_init_w);
            if (wb_valid && (!m_rd_legal || m_conflict)) m_err = 1'b1;
            if (wb_valid && m_rd_legal && !m_conflict && wb_src != VECTOR_TO_SCALAR)
                for (int l = 0; l < TPW; l++)
                    if (wb_mask[l]) m_gpr[wb_warp][l][wb_rd] = m_src(l);
            // Read sees the write of this same cycle.
            m_resp_valid = m_acc_rd;
            if (m_acc_rd)
                for (int l = 0; l < TPW; l++) begin
                    m_rs1[l] = rd_mask[l] ? m_read(rd_warp, rd_rs1, l) : '0;
                    m_rs2[l] = rd_mask[l] ? m_read(rd_warp, rd_rs2, l) : '0;
                end
            if (m_acc_init)
                for (int r = 0; r < NR; r++) m_busy[init_warp][r] = 1'b0;
            if (wb_valid) m_busy[wb_warp][wb_rd] = 1'b0;
            if (m_acc_rd && rd_reserve && rd_dst >= 1 && rd_dst <= NR - 4)
                m_busy[rd_warp][rd_dst] = 1'b1;
            if (m_init_age >= 1 && m_init_age <= NR - 4) begin
                for (int l = 0; l < TPW; l++) m_gpr[m_init_w][l][m_init_age] = '0;
                m_init_age++;
            end else if (m_init_age == NR - 3) begin
                m_bid[m_init_w] = m_init_bid;
                m_bsz[m_init_w] = m_init_bsz;
                m_init_age = 0;
            end
            if (m_acc_init) begin
                m_init_age = 1;
                m_init_w   = init_warp;
                m_init_bid = init_block_id;
                m_init_bsz = init_block_size;
            end
        end
    end

    always @(negedge clk) begin
        chk("rd_ready", rd_ready, reset_n && m_init_age == 0 &&
            !m_busy[rd_warp][rd_rs1] && !m_busy[rd_warp][rd_rs2]);
        chk("init_ready", init_ready, m_init_age == 0);
        chk("resp_valid", resp_valid, m_resp_valid);
        chk("err_sticky", err_sticky, m_err);
        for (int l = 0; l < TPW; l++) begin
            chk($sformatf("rs1_data[%0d]", l), rs1_data[l], m_rs1[l]);
            chk($sformatf("rs2_data[%0d]", l), rs2_data[l], m_rs2[l]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int w, input int r1, input int r2, input int res, input int dst);
        rd_valid = 1'b1; rd_warp = 2'(w); rd_rs1 = 5'(r1); rd_rs2 = 5'(r2);
        rd_mask = '1; rd_reserve = res[0]; rd_dst = 5'(dst);
        tick();
        rd_valid = 1'b0; rd_reserve = 1'b0;
    endtask

    task automatic do_wb(input int w, input int r, input int mask, input reg_input_mux_t src,
                         input int imm);
        wb_valid = 1'b1; wb_warp = 2'(w); wb_rd = 5'(r); wb_mask = TPW'(mask);
        wb_src = src; wb_imm = data_t'(imm);
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic start_init(input int w, input int bid, input int bsz);
        init_valid = 1'b1; init_warp = 2'(w);
        init_block_id = data_t'(bid); init_block_size = data_t'(bsz);
        tick();
        init_valid = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!init_ready && n < 200) begin
            n++;
            tick();
        end
        if (n >= 200) chk({name, "_timeout"}, 1, 0);
    endtask

    initial begin
        int n;
        for (int l = 0; l < TPW; l++) begin
            alu_out[l] = data_t'(l * 10);
            lsu_out[l] = '0;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_init_ready", init_ready, 1);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_err", err_sticky, 0);
        chk("rst_rs1_0", rs1_data[0], 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // 1: init warp 2 and read special registers
        start_init(2, 5, 64);
        n = 0;
        while (!init_ready && n < 100) begin
            n++;
            tick();
        end
        chk("init_busy_cycles", n, 29);
        do_read(2, 29, 30, 0, 0);
        chk("t1_resp_valid", resp_valid, 1);
        chk("t1_tid_lane3", rs1_data[3], 35);
        chk("t1_bid_lane3", rs2_data[3], 5);
        do_read(2, 31, 0, 0, 0);
        chk("t1_bsz_lane3", rs1_data[3], 64);

        // 2: masked ALU write-back
        do_wb(1, 7, 'h00FF, ALU_OUT, 0);
        do_read(1, 7, 0, 0, 0);
        chk("t2_resp_valid", resp_valid, 1);
        chk("t2_lane5", rs1_data[5], 50);
        chk("t2_lane12", rs1_data[12], 0);
        tick();
        chk("t2_resp_pulse", resp_valid, 0);
        chk("t2_hold_lane5", rs1_data[5], 50);

        // 3: reservation stalls the read until the write-back lands
        do_read(0, 1, 0, 1, 9);
        rd_valid = 1'b1; rd_warp = 2'd0; rd_rs1 = 5'd9; rd_rs2 = 5'd0; rd_mask = '1;
        #1 chk("t3_stall", rd_ready, 0);
        wb_valid = 1'b1; wb_warp = 2'd0; wb_rd = 5'd9; wb_mask = '1;
        wb_src = IMMEDIATE; wb_imm = 'hABCD;
        #1 chk("t3_stall_wb_cycle", rd_ready, 0);
        tick();
        wb_valid = 1'b0;
        #1 chk("t3_ready_after_wb", rd_ready, 1);
        tick();
        rd_valid = 1'b0;
        chk("t3_resp_valid", resp_valid, 1);
        chk("t3_lane0", rs1_data[0], 'hABCD);
        chk("t3_lane15", rs1_data[15], 'hABCD);

        // 4: write-first bypass
        wb_valid = 1'b1; wb_warp = 2'd3; wb_rd = 5'd4; wb_mask = '1;
        wb_src = IMMEDIATE; wb_imm = 7;
        do_read(3, 4, 0, 0, 0);
        wb_valid = 1'b0;
        chk("t4_bypass_lane0", rs1_data[0], 7);
        chk("t4_bypass_lane9", rs1_data[9], 7);

        // 5: illegal write-backs
        chk("t5_err_clean", err_sticky, 0);
        do_wb(0, 0, 'hFFFF, IMMEDIATE, 5);
        chk("t5_err_r0", err_sticky, 1);
        do_wb(0, 30, 'hFFFF, IMMEDIATE, 123);
        start_init(1, 9, 9);
        for (int i = 0; i < 8; i++) tick();
        do_wb(1, 2, 'hFFFF, IMMEDIATE, 99);
        wait_init("t5_init");
        do_read(1, 2, 0, 0, 0);
        chk("t5_init_warp_wb_dropped", rs1_data[0], 0);
        do_read(0, 30, 0, 0, 0);
        chk("t5_bid_not_written", rs1_data[4], 0);
        chk("t5_r0_zero", rs2_data[4], 0);
        chk("t5_err_sticky", err_sticky, 1);

        // 6: reset mid-CLEAR
        do_read(2, 31, 0, 0, 0);
        start_init(0, 1, 1);
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0;
        #1;
        chk("t6_resp_valid", resp_valid, 0);
        chk("t6_rs1_zero", rs1_data[3], 0);
        chk("t6_init_ready", init_ready, 1);
        chk("t6_rd_ready", rd_ready, 0);
        chk("t6_err", err_sticky, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("t6_idle_after", init_ready, 1);
        do_read(2, 30, 0, 0, 0);
        chk("t6_bid_cleared", rs1_data[0], 0);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rd_valid   = ($urandom_range(0, 1) == 1);
            rd_warp    = 2'($urandom);
            rd_rs1     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            rd_rs2     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            rd_mask    = TPW'($urandom);
            rd_reserve = ($urandom_range(0, 2) == 0);
            rd_dst     = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(1, 6));
            wb_valid   = ($urandom_range(0, 4) < 2);
            wb_warp    = 2'($urandom);
            wb_rd      = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(1, 6));
            wb_mask    = TPW'($urandom);
            wb_src     = reg_input_mux_t'($urandom_range(0, 3));
            wb_imm     = data_t'($urandom);
            for (int l = 0; l < TPW; l++) begin
                alu_out[l] = data_t'($urandom);
                lsu_out[l] = data_t'($urandom);
            end
            init_valid      = ($urandom_range(0, 99) == 0);
            init_warp       = 2'($urandom);
            init_block_id   = data_t'($urandom);
            init_block_size = data_t'($urandom);
            tick();
        end
        rd_valid = 1'b0; wb_valid = 1'b0; init_valid = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/warp_bank_reg_file.md
Name: warp_bank_reg_file

Overview:
Multi-warp successor to the single-warp per-thread register file. It holds NUM_WARPS × THREADS_PER_WARP register sets of NUM_REGS entries each. It adds:
- a 1-cycle registered read-response handshake
- a per-warp scoreboard that stalls reads of registers with pending writes
- a masked write-back port
- a multi-cycle warp-init sequencer that clears general registers and loads the special registers

It sits between the warp scheduler/decoder and the per-thread ALU/LSU lanes.

Parameters:
NUM_WARPS, 4, warps held
THREADS_PER_WARP, 16, lanes per warp
NUM_REGS, 32, registers per thread (≥8, power of 2)
DATA_WIDTH, `DATA_WIDTH, register width
Derived: WW=$clog2(NUM_WARPS), RW=$clog2(NUM_REGS); TID=NUM_REGS-3, BID=NUM_REGS-2, BSZ=NUM_REGS-1; writable range 1..NUM_REGS-4

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
init_valid  in  1  start warp init
init_ready  out  1  sequencer idle
init_warp  in  WW  warp to init
init_block_id  in  DATA_WIDTH  loaded into BID
init_block_size  in  DATA_WIDTH  loaded into BSZ
rd_valid  in  1  read request
rd_ready  out  1  request accepted this cycle
rd_warp  in  WW  warp
rd_rs1, rd_rs2  in  RW each  source indices
rd_mask  in  THREADS_PER_WARP  lane mask
rd_reserve  in  1  mark rd_dst busy on acceptance
rd_dst  in  RW  destination to reserve
resp_valid  out  1  response strobe
rs1_data, rs2_data  out  data_t[THREADS_PER_WARP]  operands
wb_valid  in  1  write-back
wb_warp  in  WW
wb_rd  in  RW
wb_mask  in  THREADS_PER_WARP
wb_src  in  reg_input_mux_t  ALU_OUT/LSU_OUT/IMMEDIATE/VECTOR_TO_SCALAR
alu_out, lsu_out  in  data_t[THREADS_PER_WARP]
wb_imm  in  DATA_WIDTH
err_sticky  out  1  illegal write-back seen

Behaviour:
- Reset (async, reset_n=0):
  - All registers 0; scoreboard 0; FSM IDLE.
  - Outputs: resp_valid=0, rs*_data=0, err_sticky=0, init_ready=1, rd_ready=0.
  - Reset asserted mid-init aborts the init with no partial state retained.
- Register 0 always reads 0. TID/BID/BSZ are never written by wb.
  - TID reads warp*THREADS_PER_WARP+lane, computed combinationally on read; it is not stored.
  - BID/BSZ are stored per warp.
- Init FSM:
  - IDLE: init_valid&init_ready → CLEAR. Latch warp, block_id, block_size; clear that warp's scoreboard; cnt=1.
  - CLEAR: each cycle zero register cnt of that warp in all lanes; cnt++. After cnt=NUM_REGS-4, go to LOAD. Duration is NUM_REGS-4 cycles.
  - LOAD: write BID/BSZ for the warp; → IDLE.
  - init_ready=1 only in IDLE.
- Read:
  - rd_ready=1 iff FSM is IDLE and neither busy[rd_warp][rd_rs1] nor busy[rd_warp][rd_rs2] is set.
  - Hazard uses scoreboard state before the current cycle's wb clear. This is a conservative 1-cycle stall.
  - Accepted when rd_valid&rd_ready. resp_valid pulses exactly 1 cycle later with registered data.
  - Lanes with rd_mask=0 return 0. rs*_data hold their value when resp_valid=0.
  - Write-first bypass: a wb to the same warp/register/lane in the acceptance cycle is reflected in the response.
- Reserve:
  - On acceptance with rd_reserve=1 and rd_dst in 1..NUM_REGS-4, set busy[rd_warp][rd_dst].
  - rd_dst outside that range: no reservation.
- Write-back:
  - wb_valid with wb_rd in the writable range writes lanes with wb_mask=1 from the selected source.
  - VECTOR_TO_SCALAR: no register write.
  - Any wb_valid clears busy[wb_warp][wb_rd].
  - Same-cycle reserve and clear of the same bit: set wins.
- Illegal write-backs set err_sticky; err_sticky clears only on reset. A write-back is illegal if:
  - wb_rd is 0 or ≥TID (discarded), or
  - wb_warp equals the warp currently being initialised (FSM not IDLE; discarded).
- No ready on wb: it is always consumed in one cycle.

Decomposition:
- Shared package (common.sv): data_t, reg_input_mux_t, and a new init_state_t (IDLE/CLEAR/LOAD).
- TID/BID/BSZ offsets are localparams derived from NUM_REGS.
- One sub-module is natural: reg_scoreboard. It holds NUM_WARPS×NUM_REGS busy bits, with set/clear ports and a two-index hazard query.

Test Plan:
1. Reset, then init warp 2 (block_id=5, block_size=64). init_ready stays low for 29 cycles (NUM_REGS=32). Read r29/r30/r31, mask 0xFFFF → lane 3 returns 35, 5, 64.
2. wb warp1 r7 ALU_OUT with mask 0x00FF (lanes = lane*10). Read r7 → lanes 0–7 = lane*10, lanes 8–15 = 0. Next cycle resp_valid=1.
3. Read with rd_reserve, rd_dst=9, warp0. Next read of rs1=9 → rd_ready=0. wb warp0 r9 IMMEDIATE 0xABCD. One cycle later rd_ready=1; response is 0xABCD in all lanes.
4. Same-cycle wb warp3 r4 IMMEDIATE 7 and read warp3 rs1=4 → response 7 (bypass).
5. wb to r0, r30, and to the warp under init → registers unchanged, err_sticky=1. Read r0 → 0.
6. Assert reset_n=0 mid-CLEAR → outputs at reset values immediately. FSM is IDLE and init_ready=1 after release.
